// File: rtl/sensor_sample_scheduler.sv
// sensor_sample_scheduler
//   Builds one coherent fusion sample frame per sample period. Each frame reads Accel1,
//   Accel2 and Gyro in turn over one shared read-request interface. Each read is held until
//   ReadValid arrives or the per-read timeout expires. The three values are then published
//   together, followed by a DataReady pulse. Frame ticks that arrive while a frame is still
//   running are dropped and counted as overruns.
//
// Optional feature: define SAMPLE_SEQ_EN to add the SampleSeq frame counter output.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, dominant
//   Enable     1 = schedule frames, 0 = no new frame starts
//   ReadReq    read request to the sensor bus controller
//   ReadAddr   channel address, valid while ReadReq = 1 (0 otherwise)
//   ReadValid  one-cycle strobe, ReadData valid for the current request
//   ReadData   sensor sample
//   Accel1     latched accelerometer axis 1
//   Accel2     latched accelerometer axis 2
//   Gyro       latched gyro rate
//   DataReady  frame-valid pulse, PULSE_CYCLES long
//   Fault      sticky per-channel timeout flags {Gyro, Accel2, Accel1}
//   Overrun    saturating count of dropped frame ticks
//   SampleSeq  (SAMPLE_SEQ_EN only) wrapping count of published frames
//   Busy       high whenever the FSM is not idle
module sensor_sample_scheduler #(
  parameter int unsigned PERIOD       = 100000,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter logic [2:0]  ADDR_ACCEL1  = 3'd0,
  parameter logic [2:0]  ADDR_ACCEL2  = 3'd1,
  parameter logic [2:0]  ADDR_GYRO    = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  output logic        ReadReq,
  output logic [2:0]  ReadAddr,
  input  logic        ReadValid,
  input  logic [9:0]  ReadData,
  output logic [9:0]  Accel1,
  output logic [9:0]  Accel2,
  output logic [9:0]  Gyro,
  output logic        DataReady,
  output logic [2:0]  Fault,
  output logic [7:0]  Overrun,
`ifdef SAMPLE_SEQ_EN
  output logic [15:0] SampleSeq,
`endif
  output logic        Busy
);

  localparam int unsigned PeriodW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(PERIOD - 1);
  localparam logic [WaitW-1:0]   WaitLast   = WaitW'(TIMEOUT - 1);
  localparam logic [3:0]         PulseLast  = 4'(PULSE_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StStore, StPulse} state_e;

  state_e              state_q, state_d;
  logic [PeriodW-1:0]  per_cnt_q, per_cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [1:0]          idx_q, idx_d;
  logic                gap_q, gap_d;
  logic [3:0]          pulse_q, pulse_d;
  logic [9:0]          sh_a1_q, sh_a1_d, sh_a2_q, sh_a2_d, sh_g_q, sh_g_d;
  logic [9:0]          a1_q, a1_d, a2_q, a2_d, g_q, g_d;
  logic [2:0]          fault_q, fault_d;
  logic [7:0]          overrun_q, overrun_d;
`ifdef SAMPLE_SEQ_EN
  logic [15:0]         seq_q, seq_d;
`endif

  logic tick;
  logic timed_out;
  logic read_done;

  always_comb begin
    tick      = Enable && (per_cnt_q == PeriodLast);
    timed_out = (wait_q == WaitLast);
    read_done = 1'b0;

    if (!Enable || tick) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    pulse_d   = pulse_q;
    sh_a1_d   = sh_a1_q;
    sh_a2_d   = sh_a2_q;
    sh_g_d    = sh_g_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    g_d       = g_q;
    fault_d   = fault_q;
    overrun_d = overrun_q;
`ifdef SAMPLE_SEQ_EN
    seq_d     = seq_q;
`endif

    // A tick that finds a frame still running is dropped; the frame itself is untouched.
    if (tick && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          idx_d   = 2'd0;
          gap_d   = 1'b0;
          wait_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (gap_q) begin
          // Single request-low cycle between consecutive channels.
          gap_d = 1'b0;
        end else begin
          wait_d    = wait_q + 1'b1;
          read_done = ReadValid || timed_out;
          // Data wins over a timeout reached in the same cycle.
          if (ReadValid) begin
            case (idx_q)
              2'd0:    sh_a1_d = ReadData;
              2'd1:    sh_a2_d = ReadData;
              default: sh_g_d  = ReadData;
            endcase
          end else if (timed_out) begin
            fault_d = fault_q | (3'b001 << idx_q);
          end
          if (read_done) begin
            wait_d = '0;
            if (idx_q == 2'd2) begin
              state_d = StStore;
            end else begin
              idx_d = idx_q + 2'd1;
              gap_d = 1'b1;
            end
          end
        end
      end
      StStore: begin
        a1_d    = sh_a1_q;
        a2_d    = sh_a2_q;
        g_d     = sh_g_q;
        pulse_d = 4'd0;
`ifdef SAMPLE_SEQ_EN
        seq_d   = seq_q + 16'd1;
`endif
        state_d = StPulse;
      end
      StPulse: begin
        // pulse_q == 0 is a setup cycle so data is stable before DataReady rises.
        pulse_d = pulse_q + 4'd1;
        if (pulse_q == PulseLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      wait_q    <= '0;
      idx_q     <= 2'd0;
      gap_q     <= 1'b0;
      pulse_q   <= 4'd0;
      sh_a1_q   <= '0;
      sh_a2_q   <= '0;
      sh_g_q    <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      g_q       <= '0;
      fault_q   <= '0;
      overrun_q <= '0;
`ifdef SAMPLE_SEQ_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pulse_q   <= pulse_d;
      sh_a1_q   <= sh_a1_d;
      sh_a2_q   <= sh_a2_d;
      sh_g_q    <= sh_g_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      g_q       <= g_d;
      fault_q   <= fault_d;
      overrun_q <= overrun_d;
`ifdef SAMPLE_SEQ_EN
      seq_q     <= seq_d;
`endif
    end
  end

  always_comb begin
    ReadReq  = (state_q == StReq) && !gap_q;
    ReadAddr = 3'd0;
    if (ReadReq) begin
      case (idx_q)
        2'd0:    ReadAddr = ADDR_ACCEL1;
        2'd1:    ReadAddr = ADDR_ACCEL2;
        default: ReadAddr = ADDR_GYRO;
      endcase
    end
  end

  assign DataReady = (state_q == StPulse) && (pulse_q != 4'd0);
  assign Busy      = (state_q != StIdle);
  assign Accel1    = a1_q;
  assign Accel2    = a2_q;
  assign Gyro      = g_q;
  assign Fault     = fault_q;
  assign Overrun   = overrun_q;
`ifdef SAMPLE_SEQ_EN
  assign SampleSeq = seq_q;
`endif

endmodule

// File: tb/tb_sensor_sample_scheduler.sv
// Bench for sensor_sample_scheduler. Instance A (PERIOD=32, TIMEOUT=8) runs a table of
// frames, then reset-mid-frame and enable-drop sequences. Instance B (PERIOD=16) covers
// overrun counting and saturation.
module tb_sensor_sample_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       rst_a, en_a, req_a, rv_a, dr_a, busy_a;
  logic [2:0] addr_a, fault_a;
  logic [9:0] rd_a, a1_a, a2_a, g_a;
  logic [7:0] ovr_a;
  logic       rst_b, en_b, req_b, rv_b, dr_b, busy_b;
  logic [2:0] addr_b, fault_b;
  logic [9:0] rd_b, a1_b, a2_b, g_b;
  logic [7:0] ovr_b;
`ifdef SAMPLE_SEQ_EN
  logic [15:0] seq_a, seq_b;
`endif

  sensor_sample_scheduler #(.PERIOD(32), .TIMEOUT(8), .PULSE_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst_a), .Enable(en_a), .ReadReq(req_a), .ReadAddr(addr_a),
    .ReadValid(rv_a), .ReadData(rd_a), .Accel1(a1_a), .Accel2(a2_a), .Gyro(g_a),
    .DataReady(dr_a), .Fault(fault_a), .Overrun(ovr_a),
`ifdef SAMPLE_SEQ_EN
    .SampleSeq(seq_a),
`endif
    .Busy(busy_a)
  );

  sensor_sample_scheduler #(.PERIOD(16), .TIMEOUT(255), .PULSE_CYCLES(2)) dut_b (
    .clk(clk), .reset(rst_b), .Enable(en_b), .ReadReq(req_b), .ReadAddr(addr_b),
    .ReadValid(rv_b), .ReadData(rd_b), .Accel1(a1_b), .Accel2(a2_b), .Gyro(g_b),
    .DataReady(dr_b), .Fault(fault_b), .Overrun(ovr_b),
`ifdef SAMPLE_SEQ_EN
    .SampleSeq(seq_b),
`endif
    .Busy(busy_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder config per address: delay = edges from request rise to the sampled ReadValid,
  // 0 = never answer.
  int         dly_a[3];
  logic [9:0] dat_a[3];
  int         dly_b[3];
  logic [9:0] dat_b[3];

  initial begin : resp_a
    int k;
    int ix;
    bit prev;
    k = 0; prev = 1'b0; rv_a = 1'b0; rd_a = '0;
    forever begin
      @(posedge clk); #1;
      if (req_a && !prev) k = 1;
      else if (req_a) k++;
      prev = req_a;
      ix = int'(addr_a);
      if (req_a && ix < 3 && dly_a[ix] != 0 && k == dly_a[ix]) begin
        rv_a = 1'b1; rd_a = dat_a[ix];
      end else begin
        rv_a = 1'b0; rd_a = 10'($urandom);
      end
    end
  end

  initial begin : resp_b
    int k;
    int ix;
    bit prev;
    k = 0; prev = 1'b0; rv_b = 1'b0; rd_b = '0;
    forever begin
      @(posedge clk); #1;
      if (req_b && !prev) k = 1;
      else if (req_b) k++;
      prev = req_b;
      ix = int'(addr_b);
      if (req_b && ix < 3 && dly_b[ix] != 0 && k == dly_b[ix]) begin
        rv_b = 1'b1; rd_b = dat_b[ix];
      end else begin
        rv_b = 1'b0; rd_b = 10'($urandom);
      end
    end
  end

  // Scoreboard: expected frames are queued when their stimulus is set up and popped on
  // each DataReady rising edge of instance A.
  typedef struct {
    logic [9:0] a1;
    logic [9:0] a2;
    logic [9:0] g;
    logic [2:0] f;
  } exp_t;
  exp_t sbq[$];

  int seq_n = 0;
  int pub_n = 0;
  int frames_a = 0;
  int dr_rise_cyc = 0;
  int len_by[3];

  initial begin : mon_a
    bit p_req, p_dr;
    int req_len, gap_len, dr_len;
    logic [29:0] prev_data;
    exp_t e;
    p_req = 1'b0; p_dr = 1'b0; req_len = 0; gap_len = 0; dr_len = 0; prev_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_a) begin
        seq_n = 0;
        pub_n = 0;
      end
      if (req_a && !p_req) begin
        check("read_addr", addr_a, 3'(seq_n % 3));
        if (seq_n % 3 != 0) check("req_gap", gap_len, 1);
        seq_n++;
        req_len = 0;
      end
      if (req_a) req_len++;
      if (!req_a && p_req) begin
        if (seq_n > 0) len_by[(seq_n - 1) % 3] = req_len;
        gap_len = 0;
      end
      if (!req_a) gap_len++;
      if (dr_a && !p_dr) begin
        frames_a++;
        pub_n++;
        dr_rise_cyc = cyc;
        dr_len = 0;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dataready: got pulse expected none");
        end else begin
          e = sbq.pop_front();
          check("frame_data", {a1_a, a2_a, g_a, fault_a}, {e.a1, e.a2, e.g, e.f});
          check("data_setup", prev_data, {e.a1, e.a2, e.g});
        end
`ifdef SAMPLE_SEQ_EN
        check("sample_seq", seq_a, 16'(pub_n));
`endif
      end
      if (dr_a) dr_len++;
      if (!dr_a && p_dr) check("dr_width", dr_len, 2);
      prev_data = {a1_a, a2_a, g_a};
      p_dr = dr_a;
      p_req = req_a;
    end
  end

  typedef struct {
    int         d0, d1, d2;
    logic [9:0] x0, x1, x2;
    logic [9:0] ea1, ea2, eg;
    logic [2:0] ef;
  } vec_t;

  initial begin : main
    vec_t vt[5];
    int   f0, en_cyc, rst_cyc, rq;

    vt[0] = '{1, 1, 1, 10'h055, 10'h0AA, 10'h3FF, 10'h055, 10'h0AA, 10'h3FF, 3'b000};
    vt[1] = '{8, 1, 1, 10'h123, 10'h0AA, 10'h3FF, 10'h123, 10'h0AA, 10'h3FF, 3'b000};
    vt[2] = '{1, 0, 1, 10'h200, 10'h155, 10'h001, 10'h200, 10'h0AA, 10'h001, 3'b010};
    vt[3] = '{2, 3, 1, 10'h3C3, 10'h111, 10'h2AA, 10'h3C3, 10'h111, 10'h2AA, 3'b010};
    vt[4] = '{0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h3C3, 10'h111, 10'h2AA, 3'b111};

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    dly_a = '{1, 1, 1}; dat_a = '{10'h0, 10'h0, 10'h0};
    dly_b = '{1, 1, 1}; dat_b = '{10'h0, 10'h0, 10'h0};
    repeat (3) @(posedge clk);
    #2;
    check("reset_a", {req_a, addr_a, a1_a, a2_a, g_a, dr_a, fault_a, ovr_a, busy_a}, 0);
    check("reset_b", {req_b, addr_b, a1_b, a2_b, g_b, dr_b, fault_b, ovr_b, busy_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Table-driven frames on instance A.
    for (int i = 0; i < 5; i++) begin
      dly_a = '{vt[i].d0, vt[i].d1, vt[i].d2};
      dat_a = '{vt[i].x0, vt[i].x1, vt[i].x2};
      sbq.push_back(exp_t'{vt[i].ea1, vt[i].ea2, vt[i].eg, vt[i].ef});
      if (i == 0) begin
        en_a = 1'b1;
        en_cyc = cyc;
      end
      f0 = frames_a;
      for (int k = 0; k < 100 && frames_a == f0; k++) begin
        @(posedge clk); #2;
      end
      check("frame_done", frames_a, f0 + 1);
      if (i == 0) check("latency", dr_rise_cyc - en_cyc, 39);
      check("req_len0", len_by[0], (vt[i].d0 == 0) ? 8 : vt[i].d0);
      check("req_len1", len_by[1], (vt[i].d1 == 0) ? 8 : vt[i].d1);
      check("req_len2", len_by[2], (vt[i].d2 == 0) ? 8 : vt[i].d2);
    end

    // Reset while the Accel2 read is outstanding.
    dly_a = '{1, 1, 1};
    dat_a = '{10'h0F0, 10'h00F, 10'h1E1};
    for (int k = 0; k < 100 && !(req_a && addr_a == 3'd1); k++) begin
      @(posedge clk); #2;
    end
    check("reached_req1", {req_a, addr_a}, {1'b1, 3'd1});
    rst_a = 1'b1;
    @(posedge clk); #2;
    check("reset_mid", {req_a, addr_a, a1_a, a2_a, g_a, dr_a, fault_a, ovr_a, busy_a}, 0);
    check("sb_empty", sbq.size(), 0);
    rst_a = 1'b0;
    rst_cyc = cyc;
    f0 = frames_a;
    for (int k = 0; k < 100 && !req_a; k++) begin
      @(posedge clk); #2;
    end
    check("restart_delay", cyc - rst_cyc, 32);
    check("no_publish_after_reset", frames_a, f0);

    // Enable drops during the Accel1 read: frame still completes, nothing follows.
    en_a = 1'b0;
    sbq.push_back(exp_t'{10'h0F0, 10'h00F, 10'h1E1, 3'b000});
    for (int k = 0; k < 100 && frames_a == f0; k++) begin
      @(posedge clk); #2;
    end
    check("drop_frame_done", frames_a, f0 + 1);
    rq = 0;
    repeat (96) begin
      @(posedge clk); #2;
      if (req_a) rq++;
    end
    check("no_req_after_disable", rq, 0);
    check("idle_after_disable", busy_a, 0);
    check("no_extra_frames", frames_a, f0 + 1);

    // Overrun on instance B: each frame with 10-cycle read latency drops two ticks.
    dly_b = '{10, 10, 10};
    dat_b = '{10'h111, 10'h222, 10'h333};
    en_b = 1'b1;
    for (int k = 0; k < 200 && !dr_b; k++) begin
      @(posedge clk); #2;
    end
    check("ovr_first", ovr_b, 2);
    check("b_data", {a1_b, a2_b, g_b, fault_b}, {10'h111, 10'h222, 10'h333, 3'b000});
    for (int k = 0; k < 200 && dr_b; k++) begin
      @(posedge clk); #2;
    end
    for (int k = 0; k < 200 && !dr_b; k++) begin
      @(posedge clk); #2;
    end
    check("ovr_second", ovr_b, 4);
    dly_b = '{0, 0, 0};
    repeat (6000) @(posedge clk);
    #2;
    check("ovr_saturate", ovr_b, 255);
    check("fault_b", fault_b, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_sample_scheduler.md
Name: sensor_sample_scheduler

Overview:
- Sequences one fusion sample frame per sample period.
- Reads the three sensor channels (Accel1, Accel2, Gyro) in turn over a single shared read-request interface to the sensor bus controller.
- Latches all three values as a coherent set, then pulses DataReady to the sensor fusion block.
- Also polices the bus with a per-read timeout and counts frame overruns.

Parameters:
- PERIOD, 100000: clock cycles between frame starts (sample rate); must be ≥ 16.
- TIMEOUT, 255: maximum cycles to wait for ReadValid per channel read.
- PULSE_CYCLES, 2: cycles DataReady stays high; range 1..15.
- ADDR_ACCEL1, 3'd0: bus address of the first accelerometer axis.
- ADDR_ACCEL2, 3'd1: bus address of the second accelerometer axis.
- ADDR_GYRO, 3'd2: bus address of the gyro.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  1 = frames scheduled; 0 = no new frame starts.
- ReadReq  out  1  read request to sensor bus controller.
- ReadAddr  out  3  channel address, valid while ReadReq = 1.
- ReadValid  in  1  one-cycle strobe: ReadData valid for the current request.
- ReadData  in  10  sensor sample.
- Accel1  out  10  latched accelerometer axis 1 to fusion.
- Accel2  out  10  latched accelerometer axis 2 to fusion.
- Gyro  out  10  latched gyro rate to fusion.
- DataReady  out  1  frame-valid pulse; fusion samples on its rising edge.
- Fault  out  3  sticky per-channel timeout flags; bit0 Accel1, bit1 Accel2, bit2 Gyro.
- Overrun  out  8  saturating count of dropped frame ticks.
- Busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (synchronous, dominant over all other inputs; also aborts any frame in progress):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The period counter and the per-read wait counter are cleared.
  - No partial frame is published after reset.
- Period counter:
  - Counts 0..PERIOD-1 and wraps while Enable = 1; held at 0 while Enable = 0.
  - Tick is asserted in the cycle the count equals PERIOD-1.
  - First tick occurs PERIOD cycles after Enable rises.
- FSM states: IDLE, REQ, STORE, PULSE.
  - IDLE: on tick, set channel index to 0 and go to REQ.
  - REQ:
    - ReadReq = 1 and ReadAddr = address of the current channel, both held stable.
    - The wait counter increments each cycle.
    - If ReadValid = 1, capture ReadData into the channel's shadow register.
    - If the wait counter reaches TIMEOUT without ReadValid, set the channel's Fault bit; the shadow register keeps its previous value.
    - In either case, ReadReq drops in the next cycle, the wait counter clears, and the index advances.
    - After index 2 completes, go to STORE; otherwise stay in REQ for the next channel. ReadReq is low for exactly 1 cycle between consecutive channels.
    - ReadValid outside REQ is ignored.
  - STORE (1 cycle): copy all three shadow registers to Accel1/Accel2/Gyro at once, then go to PULSE. Outputs change only here.
  - PULSE:
    - DataReady = 1 for PULSE_CYCLES cycles, then return to IDLE.
    - DataReady rises exactly 1 cycle after the outputs update, so the data is stable at the consumer's edge.
- Latency: in the best case (ReadValid one cycle after each request), DataReady rises 8 cycles after the tick.
- Overrun:
  - A tick while state ≠ IDLE is dropped and Overrun increments.
  - Overrun saturates at 255.
  - The frame in progress is unaffected.
- Enable falling mid-frame: the current frame completes, including publication; no further ticks are generated.
- Fault bits clear only on reset; a later successful read does not clear them.
- ReadValid arriving in the same cycle the timeout is reached: the data is accepted and the Fault bit is not set.

Optional Feature:
- Macro: SAMPLE_SEQ_EN.
- When defined:
  - Adds output SampleSeq [15:0], a wrapping frame counter.
  - SampleSeq increments in the STORE cycle and resets to 0.
  - Lets the fusion probe/debug logic detect missed frames.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: PERIOD=32, ReadValid 1 cycle after each ReadReq with data 10'h055, 10'h0AA, 10'h3FF.
  - ReadAddr sequence is 0, 1, 2.
  - Accel1=0x055, Accel2=0x0AA, Gyro=0x3FF update together.
  - DataReady rises 1 cycle later, high for 2 cycles, 8 cycles after the tick.
  - Fault=0.
- Timeout: TIMEOUT=8, no ReadValid for address 1 (prior Accel2=0x0AA).
  - ReadReq drops after 8 waiting cycles and Fault=3'b010.
  - Accel2 stays 0x0AA; the frame still publishes.
- Overrun: PERIOD=16, ReadValid delayed 10 cycles per read.
  - Each tick during a frame increments Overrun.
  - Force 300 overruns: Overrun saturates at 255.
- Reset mid-frame: assert reset while in REQ for address 1.
  - Next cycle all outputs are 0 and ReadReq=0.
  - No DataReady pulse; the next frame starts PERIOD cycles after reset release.
- Enable drop: deassert Enable during REQ for address 0.
  - The frame completes with one DataReady pulse.
  - No ReadReq for 3×PERIOD cycles afterwards.
- Timeout/valid collision: ReadValid in exactly the TIMEOUT cycle with data 0x123.
  - Data is captured and the Fault bit stays 0.
  - With SAMPLE_SEQ_EN defined, SampleSeq increments by 1 per published frame.
